inst_type_decoder: RTL
======================

// Module: inst_type_decoder
// PURPOSE
//  - Upstream neighbour of the function decoder, sitting between instruction fetch and function decode.
//  - Buffers fetched instructions in a small FIFO and pops one per cycle when not stalled.
//  - Classifies the opcode into one-hot is_* type flags and extracts funct3, funct7, rd, rs1 and rs2.
//  - Issues a one-cycle dec_en per popped instruction. The function decoder consumes dec_en, is_* and funct*.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of two, >= 2
//  XLEN    32  PC/instruction width; fixed at 32 for RV32I
// PORTS
//  CLK          in   1   clock, rising edge
//  RST          in   1   synchronous reset, active-high
//  if_vld       in   1   fetch presents if_inst/if_pc
//  if_inst      in   32  fetched instruction word
//  if_pc        in   32  PC of if_inst
//  if_rdy       out  1   buffer can accept; push = if_vld & if_rdy
//  dec_stall    in   1   downstream stall; no pop while high
//  flush        in   1   redirect (taken branch/jump); discard all buffered instructions
//  dec_en       out  1   one-cycle pulse: new instruction on decode outputs
//  dec_pc       out  32  PC of current decoded instruction
//  funct3       out  3   inst[14:12]
//  funct7       out  7   inst[31:25]
//  rd/rs1/rs2   out  5   inst[11:7] / inst[19:15] / inst[24:20]
//  is_OP, is_OP_IMM, is_LUI, is_AUIPC, is_JAL, is_JALR, is_BRANCH, is_LOAD, is_STORE,
//  is_MISC_MEM, is_SYSTEM   out 1 each   one-hot opcode class; all 0 when illegal
//  dec_illegal  out  1   pulses with dec_en when the opcode is unrecognised or inst[1:0] != 2'b11
// BEHAVIOUR
//  - Reset (RST=1 at the clock edge): FIFO empty; count=0; if_rdy=0 during reset and 1 in the cycle after.
//    All decode outputs are 0, including dec_en, dec_illegal, dec_pc and every is_*.
//  - if_rdy = (count != DEPTH), driven from the registered count.
//    A push is refused when full even if a pop occurs in the same cycle.
//  - Push: {if_pc, if_inst} written at the tail; count+1.
//  - Pop = ~empty & ~dec_stall & ~flush.
//    Push and pop in the same cycle: count is unchanged and both pointers advance.
//  - Latency: an instruction pushed at edge N is popped no earlier than edge N+1.
//    dec_en and its decode fields are registered and valid in the cycle after the pop edge.
//    Minimum if_vld-to-dec_en latency is 2 cycles.
//  - dec_en = 1 for exactly one cycle per popped instruction.
//    When stalled or empty: dec_en = 0 and all other decode outputs hold their last values.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
//  - Opcode map, inst[6:0]: 0110011 OP, 0010011 OP_IMM, 0110111 LUI, 0010111 AUIPC, 1101111 JAL,
//    1100111 JALR, 1100011 BRANCH, 0000011 LOAD, 0100011 STORE, 0001111 MISC_MEM, 1110011 SYSTEM.
//    Any other value: is_* = 0 and dec_illegal = 1.
//  - flush: at the edge, FIFO is emptied, pointers reset, count=0.
//    A push in the same cycle is dropped; dec_en=0 in the next cycle.
//    flush has priority over push and pop.
//  - flush together with dec_stall: flush wins.
//  - RST mid-stream: identical to the power-on reset state; in-flight entries are lost.
// STRUCTURE
//  - Shared header rv32i_defines.vh holds the OPCODE_* macros, shared with the function decoder's FUNCT_* macros.
//  - Sub-module sync_fifo (DEPTH, WIDTH=64) provides storage, pointers, count, full and empty, with synchronous clear.
//  - Top level holds the opcode classifier and the output register stage.
// TESTING
//  - Reset: hold RST 2 cycles -> dec_en=0, all is_*=0, if_rdy=0; if_rdy=1 in the cycle after RST falls.
//  - Single ADD: push 0x003100B3 @PC 0x0 -> 2 cycles later dec_en=1, is_OP=1, funct3=0, funct7=0, rd=1, rs1=2, rs2=3.
//  - Fill and stall: dec_stall=1, push 5 words -> if_rdy=0 after 4 pushes and the 5th is refused.
//    Release stall -> 4 dec_en pulses in order with PCs 0,4,8,C.
//  - Flush with a concurrent push: 3 entries buffered, flush=1 and if_vld=1 in the same cycle -> count=0 and no dec_en afterwards.
//    The next push decodes with its own PC.
//  - Illegal: push 0x00000000 and 0xFFFFFFFF -> each gives dec_en=1, dec_illegal=1, all is_*=0.
//  - Wrap: stream 2*DEPTH+1 instructions with if_vld high and random dec_stall.
//    -> Order and PCs are preserved and there are no duplicate dec_en pulses.

Source files
------------

// File: rtl/inst_type_decoder_pkg.sv
// Shared RV32I opcode constants, buffered-entry layout and opcode classifier.
// Latency: n/a (types, constants and a pure combinational function).
// Backpressure: n/a.
package inst_type_decoder_pkg;

  localparam int RV_XLEN = 32;

  // Major opcodes, inst[6:0]
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

  // One buffered fetch: PC in the upper half, instruction word in the lower half
  typedef struct packed {
    logic [RV_XLEN-1:0] pc;
    logic [RV_XLEN-1:0] inst;
  } fetch_entry_t;

  // One-hot opcode class; all zero for an illegal opcode
  typedef struct packed {
    logic op;
    logic op_imm;
    logic lui;
    logic auipc;
    logic jal;
    logic jalr;
    logic branch;
    logic load;
    logic store;
    logic misc_mem;
    logic system;
  } type_flags_t;

  // Every legal opcode ends in 2'b11, so a full 7-bit match also rejects
  // compressed/non-32-bit encodings without a separate inst[1:0] test.
  function automatic type_flags_t classify(input logic [6:0] opcode);
    type_flags_t f;
    f = '0;
    case (opcode)
      OPCODE_OP:       f.op       = 1'b1;
      OPCODE_OP_IMM:   f.op_imm   = 1'b1;
      OPCODE_LUI:      f.lui      = 1'b1;
      OPCODE_AUIPC:    f.auipc    = 1'b1;
      OPCODE_JAL:      f.jal      = 1'b1;
      OPCODE_JALR:     f.jalr     = 1'b1;
      OPCODE_BRANCH:   f.branch   = 1'b1;
      OPCODE_LOAD:     f.load     = 1'b1;
      OPCODE_STORE:    f.store    = 1'b1;
      OPCODE_MISC_MEM: f.misc_mem = 1'b1;
      OPCODE_SYSTEM:   f.system   = 1'b1;
      default:         f          = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/inst_type_decoder_if.sv
// Fetch-side and decode-side signal bundle for the instruction type decoder.
// Latency: n/a (wiring only).
// Backpressure: fetch uses if_vld/if_rdy; decode side stalls through dec_stall.
interface inst_type_decoder_if;
  import inst_type_decoder_pkg::*;

  // fetch side
  logic               if_vld;
  logic [RV_XLEN-1:0] if_inst;
  logic [RV_XLEN-1:0] if_pc;
  logic               if_rdy;

  // pipeline control
  logic               dec_stall;
  logic               flush;

  // decode side
  logic               dec_en;
  logic [RV_XLEN-1:0] dec_pc;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic [4:0]         rd;
  logic [4:0]         rs1;
  logic [4:0]         rs2;
  logic               is_OP;
  logic               is_OP_IMM;
  logic               is_LUI;
  logic               is_AUIPC;
  logic               is_JAL;
  logic               is_JALR;
  logic               is_BRANCH;
  logic               is_LOAD;
  logic               is_STORE;
  logic               is_MISC_MEM;
  logic               is_SYSTEM;
  logic               dec_illegal;

  // Fetch/control driver
  modport master (
    output if_vld, if_inst, if_pc, dec_stall, flush,
    input  if_rdy, dec_en, dec_pc, funct3, funct7, rd, rs1, rs2,
    input  is_OP, is_OP_IMM, is_LUI, is_AUIPC, is_JAL, is_JALR,
    input  is_BRANCH, is_LOAD, is_STORE, is_MISC_MEM, is_SYSTEM, dec_illegal
  );

  // Decoder block
  modport slave (
    input  if_vld, if_inst, if_pc, dec_stall, flush,
    output if_rdy, dec_en, dec_pc, funct3, funct7, rd, rs1, rs2,
    output is_OP, is_OP_IMM, is_LUI, is_AUIPC, is_JAL, is_JALR,
    output is_BRANCH, is_LOAD, is_STORE, is_MISC_MEM, is_SYSTEM, dec_illegal
  );

endinterface

// File: rtl/inst_type_decoder_sync_fifo.sv
// Synchronous FIFO with wrapping pointers, occupancy count and synchronous clear.
// Latency: entry written at edge N is visible on o_rd_dat after edge N (first-word fall-through).
// Backpressure: push ignored when full, pop ignored when empty; full is from registered count only.
module inst_type_decoder_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  // Full/empty come straight from the registered count, so a pop in the
  // same cycle never frees a slot for a push.
  assign o_full   = (r_count == FULL_CNT);
  assign o_empty  = (r_count == '0);
  assign w_push   = i_push & ~o_full & ~i_clr;
  assign w_pop    = i_pop & ~o_empty & ~i_clr;
  assign o_rd_dat = r_mem[r_rd_ptr];

  // Pointer and occupancy update; clear behaves exactly like reset
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_dat;
  end

endmodule

// File: rtl/inst_type_decoder.sv
// Buffers fetched instructions, classifies the opcode and registers decode fields with a dec_en pulse.
// Latency: 2 cycles minimum from if_vld to dec_en (push edge, then pop edge registers the outputs).
// Backpressure: if_rdy low when full or in reset; dec_stall/flush block pops and outputs hold.
module inst_type_decoder
  import inst_type_decoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic               CLK,
  input  logic               RST,
  inst_type_decoder_if.slave bus
);

  localparam int ENTRY_W = 2 * XLEN;

  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  fetch_entry_t       w_wr_entry;
  fetch_entry_t       w_rd_entry;
  logic [ENTRY_W-1:0] w_rd_dat;
  type_flags_t        w_flags;

  logic               r_dec_en;
  logic               r_dec_illegal;
  logic [XLEN-1:0]    r_dec_pc;
  logic [2:0]         r_funct3;
  logic [6:0]         r_funct7;
  logic [4:0]         r_rd;
  logic [4:0]         r_rs1;
  logic [4:0]         r_rs2;
  type_flags_t        r_flags;

  // Reset gates if_rdy directly so fetch sees "not ready" while RST is held.
  assign bus.if_rdy = ~w_full & ~RST;
  assign w_push     = bus.if_vld & ~w_full & ~bus.flush;
  assign w_pop      = ~w_empty & ~bus.dec_stall & ~bus.flush;

  assign w_wr_entry.pc   = bus.if_pc;
  assign w_wr_entry.inst = bus.if_inst;
  assign w_rd_entry      = fetch_entry_t'(w_rd_dat);
  assign w_flags         = classify(w_rd_entry.inst[6:0]);

  inst_type_decoder_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_clr    (bus.flush),
    .i_push   (w_push),
    .i_wr_dat (w_wr_entry),
    .i_pop    (w_pop),
    .o_rd_dat (w_rd_dat),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  // Output stage: capture the popped entry; otherwise only the pulses drop
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dec_en      <= 1'b0;
      r_dec_illegal <= 1'b0;
      r_dec_pc      <= '0;
      r_funct3      <= '0;
      r_funct7      <= '0;
      r_rd          <= '0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_flags       <= '0;
    end else if (w_pop) begin
      r_dec_en      <= 1'b1;
      r_dec_illegal <= ~|w_flags;
      r_dec_pc      <= w_rd_entry.pc;
      r_funct3      <= w_rd_entry.inst[14:12];
      r_funct7      <= w_rd_entry.inst[31:25];
      r_rd          <= w_rd_entry.inst[11:7];
      r_rs1         <= w_rd_entry.inst[19:15];
      r_rs2         <= w_rd_entry.inst[24:20];
      r_flags       <= w_flags;
    end else begin
      r_dec_en      <= 1'b0;
      r_dec_illegal <= 1'b0;
    end
  end

  assign bus.dec_en      = r_dec_en;
  assign bus.dec_illegal = r_dec_illegal;
  assign bus.dec_pc      = r_dec_pc;
  assign bus.funct3      = r_funct3;
  assign bus.funct7      = r_funct7;
  assign bus.rd          = r_rd;
  assign bus.rs1         = r_rs1;
  assign bus.rs2         = r_rs2;
  assign bus.is_OP       = r_flags.op;
  assign bus.is_OP_IMM   = r_flags.op_imm;
  assign bus.is_LUI      = r_flags.lui;
  assign bus.is_AUIPC    = r_flags.auipc;
  assign bus.is_JAL      = r_flags.jal;
  assign bus.is_JALR     = r_flags.jalr;
  assign bus.is_BRANCH   = r_flags.branch;
  assign bus.is_LOAD     = r_flags.load;
  assign bus.is_STORE    = r_flags.store;
  assign bus.is_MISC_MEM = r_flags.misc_mem;
  assign bus.is_SYSTEM   = r_flags.system;

endmodule
